i2c_xfer_sequencer: RTL and testbench
=====================================

Name: i2c_xfer_sequencer

Overview:
- PCLK-domain sequencer that runs one complete I2C transfer per `start` request.
- Write transfers:
  - loads the slave address;
  - pushes a burst of up to 8 bytes into the TX FIFO;
  - enables the I2C controller;
  - waits for completion.
- Read transfers: enables the I2C controller, then drains the expected byte count from the RX FIFO onto a valid-strobed output.
- It replaces software polling of the command/status bits: it drives FIFO reset, TX push, RX pop and I2C enable, with a watchdog timeout.

Parameters:
- DATA_W, 8, FIFO/data width.
- CNT_W, 4, width of byte_count (max 2^CNT_W-1, clipped to FIFO_DEPTH).
- FIFO_DEPTH, 8, TX/RX FIFO depth (2^address_size of the FIFOs).
- TIMEOUT, 4096, PCLK cycles allowed in WAIT/DRAIN before abort.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- rw  in  1  0=write, 1=read; captured with start.
- slave_addr  in  7  7-bit slave address; captured with start.
- byte_count  in  CNT_W  bytes to transfer; captured with start.
- abort  in  1  software abort, any state.
- wr_data  in  DATA_W  write byte stream.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  sequencer accepts wr_data this cycle.
- tx_full  in  1  TX FIFO write_full.
- tx_push  out  1  TX FIFO write_enable.
- tx_data  out  DATA_W  TX FIFO write_data.
- rx_empty  in  1  RX FIFO read_empty.
- rx_rdata  in  DATA_W  RX FIFO read_data.
- rx_pop  out  1  RX FIFO read_enable.
- core_idle  in  1  I2C controller idle (already synchronized to PCLK).
- fifo_rst_n  out  1  FIFO/controller reset (command bit 4 equivalent).
- i2c_en  out  1  I2C enable (command bit 7 equivalent).
- addr_out  out  8  {slave_addr, rw} to the address register.
- rd_data  out  DATA_W  read byte.
- rd_valid  out  1  one-cycle strobe per read byte.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout/abort flag; cleared by the next accepted start.

Behaviour:
- Reset values:
  - fifo_rst_n=0.
  - All other outputs 0.
  - State=IDLE.
  - Counters 0.
- fifo_rst_n goes to 1 on the first clock after reset release.
- States and transitions:
  - IDLE:
    - start=1 captures rw/addr/count into registers;
    - addr_out updates the next cycle;
    - err clears;
    - count clipped to FIFO_DEPTH;
    - count=0 -> DONE directly.
    - Otherwise: rw=0 -> FILL, rw=1 -> ENABLE.
  - FILL:
    - wr_ready = !tx_full.
    - On wr_valid&wr_ready, tx_push=1 for one cycle with tx_data=wr_data, and the byte counter increments.
    - Counter reaching count -> ENABLE.
  - ENABLE:
    - i2c_en=1 (held through WAIT/DRAIN);
    - the timeout counter clears;
    - -> WAIT after 1 cycle.
  - WAIT:
    - Write transfer: core_idle=1 with at least 2 cycles spent in WAIT -> DONE.
    - Read transfer: -> DRAIN immediately.
  - DRAIN:
    - rx_pop=1 for one cycle whenever !rx_empty and no pop was issued the previous cycle (max one pop every 2 cycles).
    - rx_rdata is captured the cycle after the pop into rd_data, with rd_valid=1.
    - After count strobes -> DONE.
  - DONE: i2c_en=0, done=1 for one cycle, -> IDLE.
  - ERROR: fifo_rst_n=0 for exactly 2 cycles, i2c_en=0, err=1, done=1 on the exit cycle, -> IDLE.
- Timeout:
  - The counter runs in WAIT and DRAIN and saturates.
  - Reaching TIMEOUT -> ERROR.
- abort=1 in any non-IDLE state -> ERROR next cycle; abort has priority over every other transition.
- abort in IDLE is ignored.
- start while busy is ignored; it is neither queued nor captured.
- Simultaneous start and abort in IDLE: start is accepted, abort is ignored.
- tx_push is never asserted when tx_full=1.
- rx_pop is never asserted when rx_empty=1.
- wr_ready=0 outside FILL.
- PRESETn low mid-transfer:
  - immediate return to IDLE with reset values;
  - no done pulse;
  - err=0.

Test Plan:
- Write 3 bytes, addr 0x50:
  - stimulus: start, rw=0, count=3, stream 0xA1/0xB2/0xC3, core_idle goes 0 then 1 after 40 cycles;
  - required: addr_out=0xA0, exactly 3 tx_push with those bytes, i2c_en high until DONE, one done pulse, err=0.
- Read 2 bytes, addr 0x3C:
  - stimulus: start, rw=1, count=2; rx_empty drops with rx_rdata 0x11 then 0x22;
  - required: addr_out=0x79, rx_pop twice with no back-to-back pops, rd_valid twice carrying 0x11 then 0x22, then done.
- Backpressure and clipping:
  - stimulus: tx_full=1 for 5 cycles mid-FILL, count=12;
  - required: no push and wr_ready=0 while tx_full=1; exactly 8 bytes pushed.
- Timeout:
  - stimulus: write with core_idle held 0;
  - required: ERROR after TIMEOUT cycles, fifo_rst_n low for exactly 2 cycles, err=1, done=1, i2c_en=0.
- Abort/restart:
  - stimulus: abort during DRAIN, then start with count=0;
  - required: err=1 after the abort; the new start clears err and gives done 2 cycles later with no i2c_en.
- Reset mid-WAIT:
  - stimulus: assert PRESETn low during WAIT;
  - required: all outputs return to reset values asynchronously, no done pulse.

Source files
------------

// File: rtl/i2c_xfer_sequencer_if.sv
// Request, FIFO and controller signals around the I2C transfer sequencer.
// The sequencer uses the slave modport; the requester side uses master.
interface i2c_xfer_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic              start;
    logic              rw;
    logic [6:0]        slave_addr;
    logic [CNT_W-1:0]  byte_count;
    logic              abort;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              tx_full;
    logic              tx_push;
    logic [DATA_W-1:0] tx_data;
    logic              rx_empty;
    logic [DATA_W-1:0] rx_rdata;
    logic              rx_pop;
    logic              core_idle;
    logic              fifo_rst_n;
    logic              i2c_en;
    logic [7:0]        addr_out;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, rw, slave_addr, byte_count, abort,
        input  wr_data, wr_valid, tx_full,
        input  rx_empty, rx_rdata, core_idle,
        output wr_ready, tx_push, tx_data, rx_pop,
        output fifo_rst_n, i2c_en, addr_out,
        output rd_data, rd_valid, busy, done, err
    );

    modport master (
        output start, rw, slave_addr, byte_count, abort,
        output wr_data, wr_valid, tx_full,
        output rx_empty, rx_rdata, core_idle,
        input  wr_ready, tx_push, tx_data, rx_pop,
        input  fifo_rst_n, i2c_en, addr_out,
        input  rd_data, rd_valid, busy, done, err
    );
endinterface

// File: rtl/i2c_xfer_sequencer.sv
// Runs one complete I2C write or read transfer per start request,
// driving FIFO reset, TX push, RX pop and controller enable.
module i2c_xfer_sequencer #(
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic PCLK,
    input  logic PRESETn,
    i2c_xfer_sequencer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [TW-1:0] T_ONE = TW'(1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_ENABLE, S_WAIT,
        S_DRAIN, S_DONE, S_ERROR
    } state_t;

    state_t            state, nxt;
    logic              rw_q;
    logic [7:0]        addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CNT_W-1:0]  pop_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic              pop_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              err_q;
    logic              fifo_up;
    logic              err_cyc;
    logic [CNT_W-1:0]  clip_cnt;
    logic              start_ok;
    logic              push_w;
    logic              pop_w;
    logic              ready_w;

    assign start_ok = (state == S_IDLE) && bus.start;
    assign clip_cnt = (int'(bus.byte_count) > FIFO_DEPTH)
                    ? CNT_W'(FIFO_DEPTH) : bus.byte_count;

    assign ready_w = (state == S_FILL) && !bus.tx_full;
    assign push_w  = ready_w && bus.wr_valid;
    // Pops are spaced so the registered FIFO data settles before the next.
    assign pop_w   = (state == S_DRAIN) && !bus.rx_empty
                   && !pop_q && (pop_cnt != cnt_q);

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (clip_cnt == '0) nxt = S_DONE;
                    else if (bus.rw) nxt = S_ENABLE;
                    else nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (push_w && (byte_cnt + C_ONE == cnt_q))
                    nxt = S_ENABLE;
            end
            S_ENABLE: nxt = S_WAIT;
            S_WAIT: begin
                if (tmo_cnt == T_LAST) nxt = S_ERROR;
                else if (rw_q) nxt = S_DRAIN;
                else if (bus.core_idle && tmo_cnt != '0)
                    nxt = S_DONE;
            end
            S_DRAIN: begin
                if (tmo_cnt == T_LAST) nxt = S_ERROR;
                else if (rd_valid_q && (rd_cnt + C_ONE == cnt_q))
                    nxt = S_DONE;
            end
            S_DONE: nxt = S_IDLE;
            S_ERROR: if (err_cyc) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (bus.abort && state != S_IDLE && state != S_ERROR)
            nxt = S_ERROR;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= S_IDLE;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            byte_cnt   <= '0;
            pop_cnt    <= '0;
            rd_cnt     <= '0;
            tmo_cnt    <= '0;
            pop_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            fifo_up    <= 1'b0;
            err_cyc    <= 1'b0;
        end else begin
            state      <= nxt;
            fifo_up    <= 1'b1;
            pop_q      <= pop_w;
            rd_valid_q <= pop_q && state == S_DRAIN && nxt == S_DRAIN;
            err_cyc    <= (state == S_ERROR) && !err_cyc;
            if (pop_q && state == S_DRAIN) rd_data_q <= bus.rx_rdata;
            if (push_w) byte_cnt <= byte_cnt + C_ONE;
            if (pop_w) pop_cnt <= pop_cnt + C_ONE;
            if (rd_valid_q) rd_cnt <= rd_cnt + C_ONE;
            if (nxt == S_ERROR && state != S_ERROR) err_q <= 1'b1;
            if (state == S_ENABLE) begin
                tmo_cnt <= '0;
            end else if ((state == S_WAIT || state == S_DRAIN)
                         && tmo_cnt != T_MAX) begin
                tmo_cnt <= tmo_cnt + T_ONE;
            end
            if (start_ok) begin
                rw_q     <= bus.rw;
                addr_q   <= {bus.slave_addr, bus.rw};
                cnt_q    <= clip_cnt;
                byte_cnt <= '0;
                pop_cnt  <= '0;
                rd_cnt   <= '0;
                err_q    <= 1'b0;
            end
        end
    end

    assign bus.wr_ready   = ready_w;
    assign bus.tx_push    = push_w;
    assign bus.tx_data    = push_w ? bus.wr_data : '0;
    assign bus.rx_pop     = pop_w;
    assign bus.fifo_rst_n = fifo_up && (state != S_ERROR);
    assign bus.i2c_en     = (state == S_ENABLE) || (state == S_WAIT)
                          || (state == S_DRAIN);
    assign bus.addr_out   = addr_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE)
                          || (state == S_ERROR && err_cyc);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Directed scenario bench for the I2C transfer sequencer with a small
// registered-read RX FIFO model.
module tb_i2c_xfer_sequencer;
    localparam int TIMEOUT = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_xfer_sequencer_if #(.DATA_W(8), .CNT_W(4)) bus ();

    i2c_xfer_sequencer #(
        .DATA_W(8), .CNT_W(4), .FIFO_DEPTH(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(clk),
        .PRESETn(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int push_n = 0, push_bad = 0, ready_bad = 0;
    int pop_n = 0, b2b = 0, pop_bad = 0, done_n = 0;
    logic pop_prev = 1'b0;
    logic [7:0] push_log[$];
    logic [7:0] rd_log[$];
    logic [7:0] wq[$];
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (bus.tx_push) begin
            push_n++;
            push_log.push_back(bus.tx_data);
            if (bus.tx_full) push_bad++;
        end
        if (bus.wr_ready && bus.tx_full) ready_bad++;
        if (bus.rx_pop) begin
            pop_n++;
            if (pop_prev) b2b++;
            if (bus.rx_empty) pop_bad++;
        end
        pop_prev = bus.rx_pop;
        if (bus.rd_valid) rd_log.push_back(bus.rd_data);
        if (bus.done) done_n++;
    end

    initial begin
        logic pop_s;
        bus.rx_empty = 1'b1;
        bus.rx_rdata = 8'h00;
        forever begin
            @(negedge clk);
            pop_s = bus.rx_pop;
            @(posedge clk);
            #1;
            if (pop_s && rxq.size() > 0) bus.rx_rdata = rxq.pop_front();
            bus.rx_empty = (rxq.size() == 0);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_bytes(input int n, input int stall_at,
                              input int stall_len);
        int sent = 0;
        int guard = 0;
        logic acc;
        while (sent < n && guard < 200) begin
            if (sent == stall_at && stall_len > 0) begin
                bus.wr_valid = 1'b1;
                bus.wr_data = wq[sent];
                bus.tx_full = 1'b1;
                repeat (stall_len) @(posedge clk);
                #1;
                bus.tx_full = 1'b0;
                stall_len = 0;
            end
            bus.wr_valid = 1'b1;
            bus.wr_data = wq[sent];
            @(negedge clk);
            acc = bus.wr_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            guard++;
        end
        bus.wr_valid = 1'b0;
        bus.wr_data = 8'h00;
    endtask

    task automatic test_reset();
        logic [32:0] v;
        repeat (3) @(posedge clk);
        @(negedge clk);
        v = {bus.fifo_rst_n, bus.busy, bus.done, bus.err, bus.i2c_en,
             bus.wr_ready, bus.tx_push, bus.rx_pop, bus.rd_valid,
             bus.addr_out, bus.rd_data, bus.tx_data};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", v);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.fifo_rst_n !== 1'b0) begin
            bad++;
            $display("FAIL fifo_rst_hold got=%b want=0", bus.fifo_rst_n);
        end
        @(negedge clk);
        total++;
        if (bus.fifo_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL fifo_rst_rel got=%b want=1", bus.fifo_rst_n);
        end
    endtask

    task automatic test_write();
        int p0, d0, l0, guard, en_lo;
        logic seen;
        p0 = push_n; d0 = done_n; l0 = push_log.size();
        wq = '{8'hA1, 8'hB2, 8'hC3};
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.rw = 1'b0;
        bus.slave_addr = 7'h50; bus.byte_count = 4'd3;
        bus.core_idle = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        total++;
        if (bus.addr_out !== 8'hA0) begin
            bad++;
            $display("FAIL wr_addr got=%h want=a0", bus.addr_out);
        end
        send_bytes(3, -1, 0);
        en_lo = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.i2c_en !== 1'b1) en_lo++;
        end
        @(posedge clk);
        #1 bus.core_idle = 1'b1;
        seen = 1'b0; guard = 0;
        while (!seen && guard < 20) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else if (bus.i2c_en !== 1'b1) en_lo++;
            guard++;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wr_done got=none want=pulse");
        end
        total++;
        if (en_lo != 0) begin
            bad++;
            $display("FAIL wr_en_held got=%0d low want=0", en_lo);
        end
        total++;
        if (bus.i2c_en !== 1'b0) begin
            bad++;
            $display("FAIL wr_en_done got=%b want=0", bus.i2c_en);
        end
        total++;
        if (bus.err !== 1'b0) begin
            bad++;
            $display("FAIL wr_err got=%b want=0", bus.err);
        end
        repeat (2) @(negedge clk);
        total++;
        if (done_n - d0 != 1) begin
            bad++;
            $display("FAIL wr_done_cnt got=%0d want=1", done_n - d0);
        end
        total++;
        if (push_n - p0 != 3) begin
            bad++;
            $display("FAIL wr_push_cnt got=%0d want=3", push_n - p0);
        end
        for (int i = 0; i < 3; i++) begin
            if (l0 + i < push_log.size()) begin
                total++;
                if (push_log[l0 + i] !== wq[i]) begin
                    bad++;
                    $display("FAIL wr_byte%0d got=%h want=%h",
                             i, push_log[l0 + i], wq[i]);
                end
            end
        end
    endtask

    task automatic test_read();
        int p0, b0, e0, d0, r0, guard;
        logic seen;
        logic [7:0] exp_rd[2];
        exp_rd[0] = 8'h11;
        exp_rd[1] = 8'h22;
        p0 = pop_n; b0 = b2b; e0 = pop_bad; d0 = done_n;
        r0 = rd_log.size();
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.rw = 1'b1;
        bus.slave_addr = 7'h3C; bus.byte_count = 4'd2;
        rxq.push_back(8'h11);
        rxq.push_back(8'h22);
        @(posedge clk);
        #1 bus.start = 1'b0;
        total++;
        if (bus.addr_out !== 8'h79) begin
            bad++;
            $display("FAIL rd_addr got=%h want=79", bus.addr_out);
        end
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.rw = 1'b0;
        bus.slave_addr = 7'h7F; bus.byte_count = 4'd1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        seen = 1'b0; guard = 0;
        while (!seen && guard < 60) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            guard++;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rd_done got=none want=pulse");
        end
        repeat (3) @(negedge clk);
        total++;
        if (pop_n - p0 != 2) begin
            bad++;
            $display("FAIL rd_pop_cnt got=%0d want=2", pop_n - p0);
        end
        total++;
        if (b2b - b0 != 0 || pop_bad - e0 != 0) begin
            bad++;
            $display("FAIL rd_pop_rule got=%0d/%0d want=0/0",
                     b2b - b0, pop_bad - e0);
        end
        total++;
        if (rd_log.size() - r0 != 2) begin
            bad++;
            $display("FAIL rd_strobes got=%0d want=2", rd_log.size() - r0);
        end
        for (int i = 0; i < 2; i++) begin
            if (r0 + i < rd_log.size()) begin
                total++;
                if (rd_log[r0 + i] !== exp_rd[i]) begin
                    bad++;
                    $display("FAIL rd_byte%0d got=%h want=%h",
                             i, rd_log[r0 + i], exp_rd[i]);
                end
            end
        end
        total++;
        if (done_n - d0 != 1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rd_busy_start got=done%0d busy%b want=done1 busy0",
                     done_n - d0, bus.busy);
        end
        total++;
        if (bus.addr_out !== 8'h79) begin
            bad++;
            $display("FAIL rd_addr_keep got=%h want=79", bus.addr_out);
        end
    endtask

    task automatic test_backpressure();
        int p0, pb0, rb0, d0, l0, guard;
        p0 = push_n; pb0 = push_bad; rb0 = ready_bad;
        d0 = done_n; l0 = push_log.size();
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back(8'(8'h10 + i));
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.rw = 1'b0;
        bus.slave_addr = 7'h22; bus.byte_count = 4'd12;
        bus.core_idle = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        send_bytes(8, 3, 5);
        bus.wr_valid = 1'b1;
        bus.wr_data = 8'hEE;
        repeat (6) @(posedge clk);
        #1 bus.wr_valid = 1'b0;
        guard = 0;
        while (bus.busy && guard < 30) begin
            @(posedge clk);
            #1 guard++;
        end
        @(negedge clk);
        total++;
        if (push_n - p0 != 8) begin
            bad++;
            $display("FAIL bp_push_cnt got=%0d want=8", push_n - p0);
        end
        total++;
        if (push_bad - pb0 != 0 || ready_bad - rb0 != 0) begin
            bad++;
            $display("FAIL bp_full got=push%0d ready%0d want=0/0",
                     push_bad - pb0, ready_bad - rb0);
        end
        for (int i = 0; i < 8; i++) begin
            if (l0 + i < push_log.size()) begin
                total++;
                if (push_log[l0 + i] !== wq[i]) begin
                    bad++;
                    $display("FAIL bp_byte%0d got=%h want=%h",
                             i, push_log[l0 + i], wq[i]);
                end
            end
        end
        total++;
        if (done_n - d0 != 1) begin
            bad++;
            $display("FAIL bp_done got=%0d want=1", done_n - d0);
        end
    endtask

    task automatic test_timeout();
        int en_cyc, guard, rst_lo, done_at;
        logic seen;
        wq = '{8'h5A};
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.rw = 1'b0;
        bus.slave_addr = 7'h50; bus.byte_count = 4'd1;
        bus.core_idle = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        send_bytes(1, -1, 0);
        en_cyc = 0; guard = 0; seen = 1'b0;
        while (!seen && guard < TIMEOUT + 50) begin
            @(negedge clk);
            if (bus.err) seen = 1'b1;
            else if (bus.i2c_en) en_cyc++;
            guard++;
        end
        total++;
        if (!seen || en_cyc != TIMEOUT + 1) begin
            bad++;
            $display("FAIL to_cycles got=%0d seen=%b want=%0d",
                     en_cyc, seen, TIMEOUT + 1);
        end
        total++;
        if (bus.i2c_en !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL to_entry got=en%b done%b want=en0 done0",
                     bus.i2c_en, bus.done);
        end
        rst_lo = (bus.fifo_rst_n === 1'b0) ? 1 : 0;
        done_at = -1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (bus.fifo_rst_n === 1'b0) rst_lo++;
            if (bus.done === 1'b1) done_at = i;
        end
        total++;
        if (rst_lo != 2) begin
            bad++;
            $display("FAIL to_fifo_rst got=%0d want=2", rst_lo);
        end
        total++;
        if (done_at != 1) begin
            bad++;
            $display("FAIL to_done got=%0d want=1", done_at);
        end
        total++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL to_err got=err%b busy%b want=err1 busy0",
                     bus.err, bus.busy);
        end
        bus.core_idle = 1'b1;
    endtask

    task automatic test_abort_restart();
        int guard, d0, en_cyc;
        logic seen;
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.rw = 1'b1;
        bus.slave_addr = 7'h3C; bus.byte_count = 4'd4;
        rxq.push_back(8'h33);
        @(posedge clk);
        #1 bus.start = 1'b0;
        seen = 1'b0; guard = 0;
        while (!seen && guard < 30) begin
            @(negedge clk);
            if (bus.rd_valid) seen = 1'b1;
            guard++;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL ab_drain got=no strobe want=strobe");
        end
        @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        total++;
        if (bus.err !== 1'b1 || bus.fifo_rst_n !== 1'b0
            || bus.i2c_en !== 1'b0) begin
            bad++;
            $display("FAIL ab_err got=err%b rst%b en%b want=1 0 0",
                     bus.err, bus.fifo_rst_n, bus.i2c_en);
        end
        guard = 0;
        while (bus.busy && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.err !== 1'b1) begin
            bad++;
            $display("FAIL ab_sticky got=%b want=1", bus.err);
        end
        d0 = done_n;
        bus.start = 1'b1; bus.abort = 1'b1;
        bus.rw = 1'b0; bus.byte_count = 4'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        total++;
        if (bus.err !== 1'b0) begin
            bad++;
            $display("FAIL ab_err_clr got=%b want=0", bus.err);
        end
        en_cyc = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.i2c_en) en_cyc++;
        end
        total++;
        if (done_n - d0 != 1 || en_cyc != 0) begin
            bad++;
            $display("FAIL ab_zero got=done%0d en%0d want=done1 en0",
                     done_n - d0, en_cyc);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL ab_idle got=busy%b err%b want=0 0",
                     bus.busy, bus.err);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        logic [32:0] v;
        wq = '{8'h77};
        d0 = done_n;
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.rw = 1'b0;
        bus.slave_addr = 7'h12; bus.byte_count = 4'd1;
        bus.core_idle = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        send_bytes(1, -1, 0);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (bus.i2c_en !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL rm_wait got=en%b busy%b want=1 1",
                     bus.i2c_en, bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        v = {bus.fifo_rst_n, bus.busy, bus.done, bus.err, bus.i2c_en,
             bus.wr_ready, bus.tx_push, bus.rx_pop, bus.rd_valid,
             bus.addr_out, bus.rd_data, bus.tx_data};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL rm_async got=%h want=0", v);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.core_idle = 1'b1;
        @(negedge clk);
        total++;
        if (done_n - d0 != 0) begin
            bad++;
            $display("FAIL rm_no_done got=%0d want=0", done_n - d0);
        end
        @(negedge clk);
        total++;
        if (bus.fifo_rst_n !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rm_release got=rst%b busy%b want=1 0",
                     bus.fifo_rst_n, bus.busy);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.rw = 1'b0;
        bus.slave_addr = 7'h00;
        bus.byte_count = 4'd0;
        bus.abort = 1'b0;
        bus.wr_data = 8'h00;
        bus.wr_valid = 1'b0;
        bus.tx_full = 1'b0;
        bus.core_idle = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_timeout();
        test_abort_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
